// File: rtl/prio_event_pkg.sv
// prio_event_pkg: shared types and the 4-line priority encoder for prio_event_capture.
package prio_event_pkg;
  localparam int TS_W = 16;
  typedef enum logic [1:0] {SRC_A = 2'd0, SRC_B = 2'd1, SRC_C = 2'd2, SRC_D = 2'd3} src_t;
  typedef struct packed {
    src_t            src;
    logic            multi;
    logic [TS_W-1:0] ts;
  } evt_rec_t;
  // Returns {src, multi}: lowest set bit wins, multi when more than one bit is set.
  function automatic logic [2:0] prio_enc4(input logic [3:0] r);
    src_t s;
    s = r[0] ? SRC_A : r[1] ? SRC_B : r[2] ? SRC_C : SRC_D;
    return {s, (r & (r - 4'd1)) != 4'd0};
  endfunction
endpackage

// File: rtl/prio_event_capture_if.sv
// prio_event_capture_if: valid/ready record stream from the capture block to its consumer.
interface prio_event_capture_if #(parameter int TS_W = 16);
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_src;
  logic            out_multi;
  logic [TS_W-1:0] out_ts;
  modport master(output out_valid, out_src, out_multi, out_ts, input out_ready);
  modport slave(input out_valid, out_src, out_multi, out_ts, output out_ready);
endinterface

// File: rtl/prio_event_fifo.sv
// prio_event_fifo: synchronous FIFO, pointers one bit wider than the address, no fall-through.
module prio_event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
  assign do_push = push_i & (~full_o | do_pop);
  // Head reads as zero while empty so reset and idle outputs are clean.
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/prio_event_capture.sv
// prio_event_capture: timestamps the highest-priority active request line and buffers it
// in a FIFO, counting events lost while the FIFO is full.
module prio_event_capture
  import prio_event_pkg::*;
#(
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req_i,
  input  logic              ovf_clr_i,
  output logic              overflow_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  prio_event_capture_if.master evt_if
);
  typedef struct packed {
    src_t            src;
    logic            multi;
    logic [TS_W-1:0] ts;
  } rec_t;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              push, full, empty, drop;
  rec_t              wrec, rrec;
  assign push = |req_i;
  assign wrec = {prio_enc4(req_i), ts_q};
  // Full implies non-empty, so only out_ready decides whether a slot frees up.
  assign drop = push & full & ~evt_if.out_ready;
  prio_event_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (evt_if.out_ready),
    .wdata_i (wrec),
    .rdata_o (rrec),
    .full_o  (full),
    .empty_o (empty)
  );
  assign evt_if.out_valid = ~empty;
  assign evt_if.out_src   = rrec.src;
  assign evt_if.out_multi = rrec.multi;
  assign evt_if.out_ts    = rrec.ts;
  assign overflow_o       = ovf_q;
  assign drop_cnt_o       = drop_q;
  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    ts_d   = ts_q + TS_W'(1);
    ovf_d  = drop | (ovf_q & ~ovf_clr_i);
    drop_d = drop ? (ovf_clr_i ? DROP_W'(1) : (&drop_q ? drop_q : drop_q + DROP_W'(1)))
                  : (ovf_clr_i ? '0 : drop_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_prio_event_capture.sv
// tb_prio_event_capture: directed vector table plus hand sequences for wrap, saturation and async reset.
module tb_prio_event_capture;
  logic       clk = 1'b0;
  logic       rst_n, rst_b_n;
  logic [3:0] req_a, req_b;
  logic       clr_a, clr_b;
  logic       ovf_a, ovf_b;
  logic [7:0] drop_a;
  logic [1:0] drop_b;
  int         n_chk = 0;
  int         n_fail = 0;

  prio_event_capture_if #(.TS_W(16)) ifa ();
  prio_event_capture_if #(.TS_W(4))  ifb ();

  prio_event_capture #(.TS_W(16), .DEPTH(4), .DROP_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .ovf_clr_i(clr_a),
    .overflow_o(ovf_a), .drop_cnt_o(drop_a), .evt_if(ifa)
  );
  prio_event_capture #(.TS_W(4), .DEPTH(4), .DROP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .req_i(req_b), .ovf_clr_i(clr_b),
    .overflow_o(ovf_b), .drop_cnt_o(drop_b), .evt_if(ifb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic        clr;
    logic        v;
    logic [1:0]  src;
    logic        m;
    logic [15:0] ts;
    logic        ovf;
    logic [7:0]  drop;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic rdy, input logic clr, input logic v,
                     input logic [1:0] src, input logic m, input logic [15:0] ts,
                     input logic ovf, input logic [7:0] drop);
    tv.push_back('{req, rdy, clr, v, src, m, ts, ovf, drop});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector i is sampled at the i-th edge after reset release, where ts == i.
    for (int i = 0; i < 5; i++) add(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
    add(4'b0100, 1, 0, 1, 2, 0, 5, 0, 0);
    add(4'b1010, 1, 0, 1, 1, 1, 6, 0, 0);
    add(4'b1000, 1, 0, 1, 3, 0, 7, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 9; i < 13; i++) add(4'b0001, 0, 0, 1, 0, 0, 9, 0, 0);
    for (int i = 1; i <= 3; i++) add(4'b0001, 0, 0, 1, 0, 0, 9, 1, 8'(i));
    add(4'b0000, 0, 1, 1, 0, 0, 9, 0, 0);
    add(4'b0000, 1, 0, 1, 0, 0, 10, 0, 0);
    add(4'b0000, 1, 0, 1, 0, 0, 11, 0, 0);
    add(4'b0000, 1, 0, 1, 0, 0, 12, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 21; i < 25; i++) add(4'b0010, 0, 0, 1, 1, 0, 21, 0, 0);
    add(4'b0010, 1, 0, 1, 1, 0, 22, 0, 0);
    add(4'b0010, 1, 0, 1, 1, 0, 23, 0, 0);
    add(4'b0000, 0, 0, 1, 1, 0, 23, 0, 0);
    add(4'b0001, 0, 0, 1, 1, 0, 23, 1, 1);
    add(4'b0001, 0, 0, 1, 1, 0, 23, 1, 2);
    add(4'b0100, 0, 1, 1, 1, 0, 23, 1, 1);
    add(4'b0000, 0, 1, 1, 1, 0, 23, 0, 0);
    add(4'b0000, 1, 0, 1, 1, 0, 24, 0, 0);
    add(4'b0000, 1, 0, 1, 1, 0, 25, 0, 0);
    add(4'b0000, 1, 0, 1, 1, 0, 26, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 36; i < 39; i++) add(4'b0001, 0, 0, 1, 0, 0, 36, 0, 0);

    rst_n = 0; rst_b_n = 0;
    req_a = 0; req_b = 0; clr_a = 0; clr_b = 0;
    ifa.out_ready = 0; ifb.out_ready = 0;
    #2;
    chk("reset valid", 32'(ifa.out_valid), 0);
    chk("reset overflow", 32'(ovf_a), 0);
    chk("reset drop_cnt", 32'(drop_a), 0);
    @(posedge clk);
    #1 rst_n = 1;

    foreach (tv[i]) begin
      req_a = tv[i].req; ifa.out_ready = tv[i].rdy; clr_a = tv[i].clr;
      tick();
      chk($sformatf("v%0d valid", i), 32'(ifa.out_valid), 32'(tv[i].v));
      if (tv[i].v) begin
        chk($sformatf("v%0d src", i), 32'(ifa.out_src), 32'(tv[i].src));
        chk($sformatf("v%0d multi", i), 32'(ifa.out_multi), 32'(tv[i].m));
        chk($sformatf("v%0d ts", i), 32'(ifa.out_ts), 32'(tv[i].ts));
      end
      chk($sformatf("v%0d overflow", i), 32'(ovf_a), 32'(tv[i].ovf));
      chk($sformatf("v%0d drop_cnt", i), 32'(drop_a), 32'(tv[i].drop));
    end

    // Three records buffered; reset between edges must empty the FIFO at once.
    req_a = 0; ifa.out_ready = 0; clr_a = 0;
    #2 rst_n = 0;
    #1;
    chk("async reset valid", 32'(ifa.out_valid), 0);
    @(posedge clk);
    #3 req_a = 4'b0001;
    rst_n = 1;
    tick();
    chk("post reset valid", 32'(ifa.out_valid), 1);
    chk("post reset ts", 32'(ifa.out_ts), 0);
    chk("post reset src", 32'(ifa.out_src), 0);
    req_a = 0; ifa.out_ready = 1;
    tick();
    chk("no stale record", 32'(ifa.out_valid), 0);

    // Narrow instance: timestamp wrap and drop counter saturation.
    ifb.out_ready = 1;
    #2 rst_b_n = 1;
    for (int i = 0; i < 15; i++) tick();
    req_b = 4'b0001;
    tick();
    chk("wrap ts15 valid", 32'(ifb.out_valid), 1);
    chk("wrap ts15", 32'(ifb.out_ts), 15);
    tick();
    chk("wrap ts0 valid", 32'(ifb.out_valid), 1);
    chk("wrap ts0", 32'(ifb.out_ts), 0);
    req_b = 0;
    tick();
    chk("wrap drained", 32'(ifb.out_valid), 0);
    req_b = 4'b0001; ifb.out_ready = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("sat drop k%0d", k), 32'(drop_b), (k <= 4) ? 0 : ((k - 4 > 3) ? 3 : k - 4));
      chk($sformatf("sat ovf k%0d", k), 32'(ovf_b), 32'(k > 4));
    end
    chk("sat head ts", 32'(ifb.out_ts), 2);
    req_b = 0; clr_b = 1;
    tick();
    chk("sat clr ovf", 32'(ovf_b), 0);
    chk("sat clr drop", 32'(drop_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prio_event_capture.md
# prio_event_capture

Upstream source of the prioritised event flags used by the RAM simulation monitor. Samples four request lines every clock, resolves the highest-priority active line (line 0 first, line 3 last), stamps it with a free-running cycle counter, and buffers the result in a small FIFO. The buffered records are offered downstream over a valid/ready handshake, so the monitor can report events without losing back-to-back occurrences.

## Interface
- `TS_W`, default 16: timestamp counter width, in bits.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- `DROP_W`, default 8: width of the dropped-event counter.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req`  in  4: event request lines. Bit 0 has the highest priority and bit 3 the lowest.
- `out_valid`  out  1: head record is available.
- `out_ready`  in  1: consumer accepts the head record this cycle.
- `out_src`  out  2: index of the winning request line in the head record.
- `out_multi`  out  1: more than one request line was active when the head record was captured.
- `out_ts`  out  TS_W: timestamp of the head record.
- `overflow`  out  1: sticky flag; at least one event was dropped.
- `drop_cnt`  out  DROP_W: saturating count of dropped events.
- `ovf_clr`  in  1: synchronous clear of `overflow` and `drop_cnt`.

## Operation
- Timestamp counter `ts`:
  - Increments every cycle.
  - Wraps from 2^TS_W−1 to 0 with no flag.
  - Reset value is 0.
- Capture: on each edge where `req != 0`, a record {src, multi, ts} is written to the FIFO.
  - `src` is the lowest set bit index of `req`.
  - `multi` is set when `popcount(req) > 1`.
  - `ts` is the counter value before that edge's increment.
- Pop: a record is removed when `out_valid && out_ready`. Pop with `out_valid=0` is ignored.
- Full FIFO with no pop in the same cycle:
  - The new event is dropped.
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at all-ones.
- Full FIFO with a pop in the same cycle: the push succeeds, nothing is dropped, and occupancy is unchanged.
- Empty FIFO with a push in the same cycle: the record becomes visible the next cycle (no fall-through).
- `ovf_clr`:
  - Clears `overflow` and `drop_cnt` to 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow=1` and `drop_cnt=1`.
- `req` lines are not latched across cycles. A level held for N cycles produces N records, one per cycle.
- Outputs when empty: `out_src`, `out_multi` and `out_ts` are don't-care. The bench must check them only while `out_valid=1`.
- Reset values: `out_valid=0`, `overflow=0`, `drop_cnt=0`, `ts=0`, FIFO pointers 0, `out_src=0`, `out_multi=0`, `out_ts=0`.
- Reset asserted mid-stream:
  - All buffered records are discarded immediately.
  - `out_valid` falls asynchronously.

## Timing
- Capture latency: `req` sampled at edge N gives `out_valid=1`, holding that record, after edge N, provided the FIFO was empty.
- Throughput: one capture per cycle and one pop per cycle, sustained concurrently.
- Handshake: `out_src`, `out_multi` and `out_ts` stay stable while `out_valid=1 && out_ready=0`.
- No combinational path from `req` to any output.
- `out_ready` affects only FIFO state at the next edge.
- `overflow` and `drop_cnt` update at the edge where the drop occurs.

## Structure
- Package `prio_event_pkg` holds:
  - `src_t` (2-bit line index), with constants `SRC_A=0`, `SRC_B=1`, `SRC_C=2`, `SRC_D=3`.
  - The packed record type `evt_rec_t` {src, multi, ts}, parameterised via a package-level `TS_W` default.
  - A `prio_enc4` function returning {src, multi}.
- Sub-module `prio_event_fifo`:
  - Synchronous FIFO parameterised by width and `DEPTH`.
  - Pointers one bit wider than the address, for full/empty detection.
  - Exposes `full`, `empty` and `push`/`pop` qualifiers.
  - The top level holds the timestamp counter, the encoder, and the drop/overflow logic.

## Test plan
- Single event: reset, then pulse `req=4'b0100` for one cycle at `ts=5` with `out_ready=1`. Expect `out_valid` for one cycle with `src=2`, `multi=0`, `ts=5`.
- Priority: `req=4'b1010` for one cycle. Expect `src=1` and `multi=1`. Then `req=4'b1000`: expect `src=3` and `multi=0`.
- Overflow (`DEPTH=4`, `out_ready=0`): hold `req=4'b0001` for 7 cycles. Expect 4 records with consecutive timestamps, `overflow=1` and `drop_cnt=3`. Then pulse `ovf_clr`: expect both cleared.
- Full with simultaneous push/pop: fill to 4 entries, then set `out_ready=1` with `req` active. Expect no drop, occupancy stays 4, and records pop in order.
- Wrap and saturate (`TS_W=4`, `DROP_W=2`):
  - Events at `ts=15` then `ts=0` are recorded with those timestamps.
  - 5 drops leave `drop_cnt=3`.
- Reset mid-stream: with 3 records buffered, assert `rst_n=0` between edges. Expect `out_valid=0` immediately. After release, expect no stale records and `ts` restarting at 0.
